// File: rtl/loader_pkg.sv
// Shared constants and FSM state type for the search-array loader.
// The LFSR constants are consumed only when LOADER_LFSR_FILL_EN is defined.
package loader_pkg;

  localparam int DEPTH  = 512;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 9;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_CNT  = (ADDR_W + 1)'(DEPTH - 1);

  // Taps 16,14,13,11 in right-shifting form: feedback from bits 0,2,3,5.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    HANDOFF,
    REPORT
  } state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR used as an alternative fill source.
// Only compiled when LOADER_LFSR_FILL_EN is defined.
`ifdef LOADER_LFSR_FILL_EN
module lfsr16
  import loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic        enable,
  output logic [15:0] q
);

  // The seed is the reset value so the register can never lock up at zero.
  always_ff @(posedge clock) begin
    if (reset || load) begin
      q <= LFSR_SEED;
    end else if (enable) begin
      q <= {^(q & LFSR_TAPS), q[15:1]};
    end
  end

endmodule
`endif

// File: rtl/search_array_loader.sv
// Fills the shared search RAM with DEPTH words, then hands off to the searcher and captures its result.
// Optional LFSR fill source is enabled by defining LOADER_LFSR_FILL_EN.
module search_array_loader
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
`ifdef LOADER_LFSR_FILL_EN
  input  logic              lfsr_mode,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_owner,
  output logic              search_start,
  input  logic              done_search,
  input  logic [15:0]       start_pos,
  input  logic [15:0]       length,
  output logic [15:0]       result_start_pos,
  output logic [15:0]       result_length,
  output logic              result_valid,
  output logic              busy,
  output logic [ADDR_W:0]   words_loaded
);

  state_t            state;
  state_t            state_next;
  logic              fill_we;
  logic [DATA_W-1:0] fill_word;
  logic              last_beat;
  logic              capture;

`ifdef LOADER_LFSR_FILL_EN
  logic        mode_q;
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .clock  (clock),
    .reset  (reset),
    .load   (state == IDLE && load_req),
    .enable (fill_we && mode_q),
    .q      (lfsr_q)
  );

  // In LFSR mode the stream is shut off and every FILL cycle writes one word.
  assign in_ready  = (state == FILL) && !mode_q;
  assign fill_we   = mode_q ? (state == FILL) : (in_valid && in_ready);
  assign fill_word = mode_q ? lfsr_q : in_data;
`else
  assign in_ready  = (state == FILL);
  assign fill_we   = in_valid && in_ready;
  assign fill_word = in_data;
`endif

  assign last_beat = fill_we && (words_loaded == LAST_CNT);
  assign capture   = (state == HANDOFF) && done_search;
  assign mem_owner = (state == FILL) || (state == DRAIN);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load_req) state_next = FILL;
      FILL:    if (last_beat) state_next = DRAIN;
      DRAIN:   state_next = HANDOFF;
      HANDOFF: if (done_search) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // search_start follows the registered state so it is high exactly while in HANDOFF.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      words_loaded     <= '0;
      search_start     <= 1'b0;
      result_start_pos <= '0;
      result_length    <= '0;
      result_valid     <= 1'b0;
`ifdef LOADER_LFSR_FILL_EN
      mode_q           <= 1'b0;
`endif
    end else begin
      mem_we       <= fill_we;
      search_start <= (state_next == HANDOFF);
      result_valid <= capture;
      if (state == IDLE && load_req) begin
        words_loaded <= '0;
`ifdef LOADER_LFSR_FILL_EN
        mode_q       <= lfsr_mode;
`endif
      end
      if (fill_we) begin
        mem_addr  <= words_loaded[ADDR_W-1:0];
        mem_wdata <= fill_word;
        if (words_loaded != DEPTH_CNT) begin
          words_loaded <= words_loaded + 1'b1;
        end
      end
      if (capture) begin
        result_start_pos <= start_pos;
        result_length    <= length;
      end
    end
  end

endmodule

// File: tb/tb_search_array_loader.sv
// Randomised self-checking bench for search_array_loader against a transaction-level model.
// Define LOADER_LFSR_FILL_EN to also exercise the LFSR fill source.
module tb_search_array_loader;

  localparam int NWORDS = 512;

  logic        clock = 1'b0;
  logic        reset;
  logic        load_req;
  logic        lfsr_mode;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_owner;
  logic        search_start;
  logic        done_search;
  logic [15:0] start_pos;
  logic [15:0] length;
  logic [15:0] result_start_pos;
  logic [15:0] result_length;
  logic        result_valid;
  logic        busy;
  logic [9:0]  words_loaded;

  int compared   = 0;
  int mismatched = 0;

  always #5 clock = ~clock;

  search_array_loader dut (
    .clock            (clock),
    .reset            (reset),
    .load_req         (load_req),
`ifdef LOADER_LFSR_FILL_EN
    .lfsr_mode        (lfsr_mode),
`endif
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_owner        (mem_owner),
    .search_start     (search_start),
    .done_search      (done_search),
    .start_pos        (start_pos),
    .length           (length),
    .result_start_pos (result_start_pos),
    .result_length    (result_length),
    .result_valid     (result_valid),
    .busy             (busy),
    .words_loaded     (words_loaded)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference LFSR sequence: taps 16,14,13,11, shifting right.
  function automatic logic [15:0] lfsrNext(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    checkOutput({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    checkOutput({tag, "_mem_owner"}, 32'(mem_owner), 32'd0);
    checkOutput({tag, "_search_start"}, 32'(search_start), 32'd0);
    checkOutput({tag, "_res_pos"}, 32'(result_start_pos), 32'd0);
    checkOutput({tag, "_res_len"}, 32'(result_length), 32'd0);
    checkOutput({tag, "_res_valid"}, 32'(result_valid), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // Issues a load and streams words until limit words are accepted.
  // The model: the k-th accepted word lands at address k one cycle after acceptance.
  task automatic applyStimulus(input int valid_pct, input int limit, input bit use_lfsr,
                               input bit noise, output int cycles);
    int          count;
    logic        beat;
    logic [15:0] exp_data;
    logic [15:0] lf;
    count     = 0;
    lf        = 16'hACE1;
    load_req  = 1'b1;
    lfsr_mode = use_lfsr;
    in_valid  = 1'b1;
    in_data   = 16'hDEAD;
    tick();
    cycles    = 1;
    load_req  = 1'b0;
    lfsr_mode = 1'b0;
    checkOutput("no_write_on_req", 32'(mem_we), 32'd0);
    checkOutput("count_cleared", 32'(words_loaded), 32'd0);
    checkOutput("busy_fill", 32'(busy), 32'd1);
    while (count < limit && cycles < 20000) begin
      in_valid = (int'($urandom_range(99)) < valid_pct);
      in_data  = 16'($urandom);
      load_req = noise && ($urandom_range(15) == 0);
      checkOutput("in_ready_fill", 32'(in_ready), use_lfsr ? 32'd0 : 32'd1);
      beat     = use_lfsr ? 1'b1 : in_valid;
      exp_data = use_lfsr ? lf : in_data;
      tick();
      cycles++;
      checkOutput("mem_we", 32'(mem_we), 32'(beat));
      checkOutput("mem_owner_fill", 32'(mem_owner), 32'd1);
      if (beat) begin
        checkOutput("mem_addr", 32'(mem_addr), 32'(count));
        checkOutput("mem_wdata", 32'(mem_wdata), 32'(exp_data));
        count++;
        lf = lfsrNext(lf);
      end
      checkOutput("words_loaded", 32'(words_loaded), 32'(count));
    end
    load_req = 1'b0;
    in_valid = 1'b0;
    if (count < limit) checkOutput("fill_timeout", 32'(count), 32'(limit));
  endtask

  // Called right after the final beat; walks DRAIN, HANDOFF and REPORT.
  task automatic finishSearch(input int delay, input logic [15:0] sp, input logic [15:0] len,
                              input bit noise);
    checkOutput("drain_start", 32'(search_start), 32'd0);
    checkOutput("drain_owner", 32'(mem_owner), 32'd1);
    checkOutput("drain_ready", 32'(in_ready), 32'd0);
    tick();
    checkOutput("start_rise", 32'(search_start), 32'd1);
    checkOutput("handoff_we", 32'(mem_we), 32'd0);
    checkOutput("handoff_owner", 32'(mem_owner), 32'd0);
    for (int i = 0; i < delay; i++) begin
      load_req    = noise && (i == 2);
      done_search = 1'b0;
      start_pos   = 16'($urandom);
      length      = 16'($urandom);
      tick();
      checkOutput("start_hold", 32'(search_start), 32'd1);
      checkOutput("no_result_yet", 32'(result_valid), 32'd0);
    end
    load_req    = 1'b0;
    done_search = 1'b1;
    start_pos   = sp;
    length      = len;
    tick();
    checkOutput("result_valid", 32'(result_valid), 32'd1);
    checkOutput("start_drop", 32'(search_start), 32'd0);
    checkOutput("result_pos", 32'(result_start_pos), 32'(sp));
    checkOutput("result_len", 32'(result_length), 32'(len));
    done_search = 1'b0;
    start_pos   = 16'hFFFF;
    length      = 16'hFFFF;
    tick();
    checkOutput("result_pulse_end", 32'(result_valid), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("result_pos_hold", 32'(result_start_pos), 32'(sp));
    checkOutput("result_len_hold", 32'(result_length), 32'(len));
    checkOutput("words_loaded_final", 32'(words_loaded), 32'(NWORDS));
  endtask

  initial begin
    int cyc;
    reset       = 1'b1;
    load_req    = 1'b0;
    lfsr_mode   = 1'b0;
    in_data     = 16'h0;
    in_valid    = 1'b0;
    done_search = 1'b0;
    start_pos   = 16'h0;
    length      = 16'h0;
    tick();
    tick();
    checkAllZero("reset");
    reset = 1'b0;
    tick();

    $display("[TB] full-rate load with 20-cycle search");
    applyStimulus(100, NWORDS, 1'b0, 1'b0, cyc);
    checkOutput("start_latency", 32'(cyc + 1), 32'd514);
    finishSearch(20, 16'd37, 16'd5, 1'b0);

    $display("[TB] sparse valid with stray load_req pulses");
    applyStimulus(50, NWORDS, 1'b0, 1'b1, cyc);
    finishSearch(int'($urandom_range(1, 40)), 16'($urandom), 16'($urandom), 1'b1);

    $display("[TB] reset at beat 200, then fresh load");
    applyStimulus(70, 200, 1'b0, 1'b1, cyc);
    reset = 1'b1;
    tick();
    checkAllZero("abort");
    reset = 1'b0;
    tick();
    applyStimulus(85, NWORDS, 1'b0, 1'b0, cyc);
    finishSearch(int'($urandom_range(0, 10)), 16'($urandom), 16'($urandom), 1'b1);

`ifdef LOADER_LFSR_FILL_EN
    $display("[TB] LFSR fill");
    applyStimulus(30, NWORDS, 1'b1, 1'b0, cyc);
    checkOutput("lfsr_latency", 32'(cyc + 1), 32'd514);
    finishSearch(5, 16'd1, 16'd2, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
